// File: rtl/step_sequencer_ctrl.sv
// 16-step pattern scheduler: key presses toggle pattern bits, a tempo counter walks a play
// cursor through the steps and emits a per-step tick plus a gate pulse for enabled steps.
module step_sequencer_ctrl #(
  parameter int unsigned CLK_PER_STEP = 1_500_000,
  parameter int unsigned GATE_CYCLES  = 750_000,
  parameter int unsigned CNT_W        = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_idx,
  input  logic        start_stop,
  input  logic        clear,
  output logic        running,
  output logic [3:0]  step_idx,
  output logic        step_tick,
  output logic        gate,
  output logic [15:0] pattern
);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLK_PER_STEP - 1);
  localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYCLES - 1);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  tempo_q, tempo_d;
  logic [CNT_W-1:0]  gcnt_q, gcnt_d;
  logic [3:0]        step_q, step_d;
  logic              tick_q, tick_d;
  logic              gate_q, gate_d;
  logic [15:0]       pattern_q, pattern_d;
  logic [3:0]        step_inc;

  assign step_inc = step_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_STOPPED;
      tempo_q   <= '0;
      gcnt_q    <= '0;
      step_q    <= '0;
      tick_q    <= 1'b0;
      gate_q    <= 1'b0;
      pattern_q <= '0;
    end else begin
      state_q   <= state_d;
      tempo_q   <= tempo_d;
      gcnt_q    <= gcnt_d;
      step_q    <= step_d;
      tick_q    <= tick_d;
      gate_q    <= gate_d;
      pattern_q <= pattern_d;
    end
  end

  // Step starts sample pattern_q, so a same-cycle toggle or clear never alters that step's gate.
  always_comb begin
    state_d   = state_q;
    tempo_d   = tempo_q;
    gcnt_d    = gcnt_q;
    step_d    = step_q;
    tick_d    = 1'b0;
    gate_d    = gate_q;
    pattern_d = pattern_q;

    if (clear) begin
      pattern_d = '0;
    end else if (key_valid) begin
      pattern_d[key_idx] = ~pattern_q[key_idx];
    end

    case (state_q)
      ST_STOPPED: begin
        tempo_d = '0;
        gcnt_d  = '0;
        step_d  = '0;
        gate_d  = 1'b0;
        if (start_stop) begin
          state_d = ST_RUNNING;
          tick_d  = 1'b1;
          gate_d  = pattern_q[0];
          gcnt_d  = GATE_LOAD;
        end
      end
      ST_RUNNING: begin
        if (start_stop) begin
          state_d = ST_STOPPED;
          tempo_d = '0;
          gcnt_d  = '0;
          step_d  = '0;
          gate_d  = 1'b0;
        end else if (tempo_q == LAST_CNT) begin
          tempo_d = '0;
          step_d  = step_inc;
          tick_d  = 1'b1;
          gate_d  = pattern_q[step_inc];
          gcnt_d  = GATE_LOAD;
        end else begin
          tempo_d = tempo_q + CNT_W'(1);
          // gcnt holds the remaining high cycles after the current one
          if (gate_q) begin
            if (gcnt_q == '0) begin
              gate_d = 1'b0;
            end else begin
              gcnt_d = gcnt_q - CNT_W'(1);
            end
          end
        end
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  assign running   = (state_q == ST_RUNNING);
  assign step_idx  = step_q;
  assign step_tick = tick_q;
  assign gate      = gate_q;
  assign pattern   = pattern_q;

endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// Directed bench for step_sequencer_ctrl with CLK_PER_STEP=8, GATE_CYCLES=3.
// Inputs change and outputs are sampled on the falling edge.
module tb_step_sequencer_ctrl;

  localparam int unsigned CPS = 8;
  localparam int unsigned GC  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_idx = 4'd0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        running;
  logic [3:0]  step_idx;
  logic        step_tick;
  logic        gate;
  logic [15:0] pattern;

  int checks = 0;
  int errors = 0;

  step_sequencer_ctrl #(
    .CLK_PER_STEP(CPS),
    .GATE_CYCLES (GC),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_idx   (key_idx),
    .start_stop(start_stop),
    .clear     (clear),
    .running   (running),
    .step_idx  (step_idx),
    .step_tick (step_tick),
    .gate      (gate),
    .pattern   (pattern)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] idx);
    key_valid = 1'b1;
    key_idx   = idx;
    nxt();
    key_valid = 1'b0;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    nxt();
    start_stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
    checks++; if (running !== 1'b0)    begin errors++; $display("FAIL reset_running got %b exp 0", running); end
    checks++; if (step_idx !== 4'd0)   begin errors++; $display("FAIL reset_step got %0d exp 0", step_idx); end
    checks++; if (step_tick !== 1'b0)  begin errors++; $display("FAIL reset_tick got %b exp 0", step_tick); end
    checks++; if (gate !== 1'b0)       begin errors++; $display("FAIL reset_gate got %b exp 0", gate); end
    checks++; if (pattern !== 16'h0)   begin errors++; $display("FAIL reset_pattern got %h exp 0000", pattern); end
  endtask

  task automatic test_toggle_clear();
    press(4'd5);
    checks++; if (pattern !== 16'h0020) begin errors++; $display("FAIL toggle5 got %h exp 0020", pattern); end
    press(4'd5);
    checks++; if (pattern !== 16'h0000) begin errors++; $display("FAIL untoggle5 got %h exp 0000", pattern); end
    press(4'd0);
    press(4'd10);
    checks++; if (pattern !== 16'h0401) begin errors++; $display("FAIL toggle0_10 got %h exp 0401", pattern); end
    clear = 1'b1;
    nxt();
    clear = 1'b0;
    checks++; if (pattern !== 16'h0000) begin errors++; $display("FAIL clear got %h exp 0000", pattern); end
    key_valid = 1'b1; key_idx = 4'd4; clear = 1'b1;
    nxt();
    key_valid = 1'b0; clear = 1'b0;
    checks++; if (pattern !== 16'h0000) begin errors++; $display("FAIL clear_vs_key got %h exp 0000", pattern); end
  endtask

  task automatic test_start_gating();
    press(4'd0);
    press(4'd2);
    checks++; if (pattern !== 16'h0005) begin errors++; $display("FAIL setup_pat got %h exp 0005", pattern); end
    pulse_ss();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got %b exp 1", running); end
    for (int k = 0; k < 24; k++) begin
      logic       eg, et;
      logic [3:0] es;
      es = 4'(k / 8);
      et = (k % 8) == 0;
      eg = ((es == 4'd0) || (es == 4'd2)) && ((k % 8) < 3);
      checks++; if (step_idx !== es)  begin errors++; $display("FAIL gating_step k=%0d got %0d exp %0d", k, step_idx, es); end
      checks++; if (step_tick !== et) begin errors++; $display("FAIL gating_tick k=%0d got %b exp %b", k, step_tick, et); end
      checks++; if (gate !== eg)      begin errors++; $display("FAIL gating_gate k=%0d got %b exp %b", k, gate, eg); end
      nxt();
    end
    pulse_ss();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_running got %b exp 0", running); end
  endtask

  task automatic test_wrap();
    int ticks;
    ticks = 0;
    pulse_ss();
    for (int k = 0; k < 128; k++) begin
      logic et;
      et = (k % 8) == 0;
      if (step_tick === 1'b1) ticks++;
      checks++; if (step_tick !== et) begin errors++; $display("FAIL wrap_tick k=%0d got %b exp %b", k, step_tick, et); end
      if (et) begin
        checks++;
        if (step_idx !== 4'(k / 8)) begin errors++; $display("FAIL wrap_step k=%0d got %0d exp %0d", k, step_idx, k / 8); end
      end
      nxt();
    end
    checks++; if (ticks != 16) begin errors++; $display("FAIL wrap_count got %0d exp 16", ticks); end
    checks++; if (step_tick !== 1'b1 || step_idx !== 4'd0) begin
      errors++; $display("FAIL wrap_to0 got tick %b step %0d exp tick 1 step 0", step_tick, step_idx);
    end
    pulse_ss();
  endtask

  task automatic test_boundary_race();
    clear = 1'b1;
    nxt();
    clear = 1'b0;
    pulse_ss();
    repeat (23) nxt();
    key_valid = 1'b1; key_idx = 4'd3;
    nxt();
    key_valid = 1'b0;
    checks++; if (step_idx !== 4'd3 || step_tick !== 1'b1) begin
      errors++; $display("FAIL race_step got step %0d tick %b exp 3 1", step_idx, step_tick);
    end
    checks++; if (pattern !== 16'h0008) begin errors++; $display("FAIL race_pattern got %h exp 0008", pattern); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (gate !== 1'b0) begin errors++; $display("FAIL race_gate k=%0d got %b exp 0", k, gate); end
      nxt();
    end
    repeat (120) nxt();
    for (int k = 0; k < 4; k++) begin
      logic eg;
      eg = k < 3;
      checks++; if (step_idx !== 4'd3) begin errors++; $display("FAIL lap2_step k=%0d got %0d exp 3", k, step_idx); end
      checks++; if (gate !== eg) begin errors++; $display("FAIL lap2_gate k=%0d got %b exp %b", k, gate, eg); end
      nxt();
    end
  endtask

  task automatic test_stop_mid_gate();
    // still running with pattern 0008, at step 3 offset 4; move into step 3 of the next lap
    repeat (4 + 120 + 1) nxt();
    checks++; if (step_idx !== 4'd3 || gate !== 1'b1) begin
      errors++; $display("FAIL midgate_pre got step %0d gate %b exp 3 1", step_idx, gate);
    end
    pulse_ss();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL midgate_running got %b exp 0", running); end
    checks++; if (gate !== 1'b0)    begin errors++; $display("FAIL midgate_gate got %b exp 0", gate); end
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL midgate_step got %0d exp 0", step_idx); end
    press(4'd0);
    start_stop = 1'b1; clear = 1'b1;
    nxt();
    start_stop = 1'b0; clear = 1'b0;
    checks++; if (running !== 1'b1)    begin errors++; $display("FAIL ssclr_running got %b exp 1", running); end
    checks++; if (pattern !== 16'h0000) begin errors++; $display("FAIL ssclr_pattern got %h exp 0000", pattern); end
    checks++; if (gate !== 1'b1)       begin errors++; $display("FAIL ssclr_gate_oldbit got %b exp 1", gate); end
    pulse_ss();
  endtask

  task automatic test_reset_mid_run();
    int ticks;
    press(4'd7);
    pulse_ss();
    repeat (57) nxt();
    checks++; if (step_idx !== 4'd7 || gate !== 1'b1) begin
      errors++; $display("FAIL rstrun_pre got step %0d gate %b exp 7 1", step_idx, gate);
    end
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    checks++; if (running !== 1'b0)   begin errors++; $display("FAIL rstrun_running got %b exp 0", running); end
    checks++; if (step_idx !== 4'd0)  begin errors++; $display("FAIL rstrun_step got %0d exp 0", step_idx); end
    checks++; if (gate !== 1'b0)      begin errors++; $display("FAIL rstrun_gate got %b exp 0", gate); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL rstrun_tick got %b exp 0", step_tick); end
    checks++; if (pattern !== 16'h0)  begin errors++; $display("FAIL rstrun_pattern got %h exp 0000", pattern); end
    ticks = 0;
    for (int k = 0; k < 20; k++) begin
      nxt();
      if (step_tick === 1'b1) ticks++;
    end
    checks++; if (ticks != 0) begin errors++; $display("FAIL rstrun_noticks got %0d exp 0", ticks); end
  endtask

  initial begin
    nxt();
    test_reset();
    test_toggle_clear();
    test_start_gating();
    test_wrap();
    test_boundary_race();
    test_stop_mid_gate();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
